// File: rtl/avalon_ram_pkg.sv
// ============================================================================
// Module  : avalon_ram_pkg
// Purpose : Shared state encodings, LFSR constants and byte-lane merge helper
//           for the Avalon-MM RAM responder.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package avalon_ram_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_ACK  = 2'd2;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Taps 16,14,13,11 expressed as a mask over value[15:0]
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [31:0] byte_merge(
        input logic [31:0] old_word,
        input logic [31:0] new_word,
        input logic [3:0]  be
    );
        logic [31:0] merged;
        merged = old_word;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) merged[8*i +: 8] = new_word[8*i +: 8];
        end
        return merged;
    endfunction

endpackage

`default_nettype wire

// File: rtl/avalon_ram_responder_if.sv
// ============================================================================
// Module  : avalon_ram_if
// Purpose : Avalon-MM bus bundle between CPU master and RAM responder.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface avalon_ram_if;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic        waitrequest;
    logic [31:0] readdata;

    modport master (
        output address, read, write, writedata, byteenable,
        input  waitrequest, readdata
    );

    modport slave (
        input  address, read, write, writedata, byteenable,
        output waitrequest, readdata
    );
endinterface

`default_nettype wire

// File: rtl/avalon_ram_lfsr.sv
// ============================================================================
// Module  : avalon_ram_lfsr
// Purpose : 16-bit Fibonacci LFSR used to jitter wait states; only built
//           when AVALON_RAM_VARWAIT_EN is defined.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module avalon_ram_lfsr
    import avalon_ram_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        advance,
    output logic [15:0] value
);

    logic [15:0] r_value;
    logic        w_feedback;

    assign w_feedback = ^(r_value & LFSR_TAPS);
    assign value      = r_value;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_value <= LFSR_SEED;
        end else if (advance) begin
            r_value <= {r_value[14:0], w_feedback};
        end
    end

endmodule

`default_nettype wire

// File: rtl/avalon_ram_responder.sv
// ============================================================================
// Module  : avalon_ram_responder
// Purpose : Avalon-MM slave RAM with programmable wait states, byte-lane
//           writes and a side preload port. Optional macro
//           AVALON_RAM_VARWAIT_EN adds LFSR-jittered wait states.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module avalon_ram_responder
    import avalon_ram_pkg::*;
#(
    parameter int          DEPTH       = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    avalon_ram_if.slave bus,
    input  logic        load_en,
    input  logic [31:0] load_addr,
    input  logic [31:0] load_data,
    output logic        protocol_err
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [31:0] mem [DEPTH];

    logic [1:0]  r_state;
    logic [8:0]  r_cnt;
    logic [31:0] r_addr;
    logic        r_rd;
    logic        r_wr;
    logic [31:0] r_wdata;
    logic [3:0]  r_be;
    logic        r_perr;

    logic             w_req;
    logic             w_accept;
    logic [8:0]       w_wait_total;
    logic [29:0]      w_word;
    logic [29:0]      w_load_word;
    logic             w_in_range;
    logic             w_load_in_range;
    logic [IDX_W-1:0] w_idx;
    logic [IDX_W-1:0] w_load_idx;
    logic             w_ack_commit;
    logic             w_load_wins;

    assign w_req    = bus.read | bus.write;
    assign w_accept = (r_state == ST_IDLE) && w_req;

`ifdef AVALON_RAM_VARWAIT_EN
    logic [15:0] w_lfsr;

    avalon_ram_lfsr u_lfsr (
        .clk     (clk),
        .reset   (reset),
        .advance (w_accept),
        .value   (w_lfsr)
    );

    assign w_wait_total = 9'(WAIT_CYCLES) + {7'd0, w_lfsr[1:0]};
`else
    assign w_wait_total = 9'(WAIT_CYCLES);
`endif

    // Word indices relative to the window base; addresses below the base wrap
    // to large values and therefore fall out of range naturally.
    assign w_word          = 30'((r_addr - BASE_ADDR) >> 2);
    assign w_load_word     = 30'((load_addr - BASE_ADDR) >> 2);
    assign w_in_range      = (w_word < 30'(DEPTH));
    assign w_load_in_range = (w_load_word < 30'(DEPTH));
    assign w_idx           = w_word[IDX_W-1:0];
    assign w_load_idx      = w_load_word[IDX_W-1:0];

    assign w_ack_commit = (r_state == ST_ACK) && w_req && r_wr && w_in_range;
    assign w_load_wins  = load_en && w_load_in_range && (w_load_idx == w_idx);

    assign bus.waitrequest = w_req && (r_state != ST_ACK);
    assign bus.readdata    = ((r_state == ST_ACK) && r_rd && !r_wr && w_in_range)
                             ? mem[w_idx] : 32'h0;
    assign protocol_err    = r_perr;

    // Memory keeps its contents through reset so preloaded programs survive.
    always_ff @(posedge clk) begin
        if (load_en && w_load_in_range) begin
            mem[w_load_idx] <= load_data;
        end
        if (w_ack_commit && !w_load_wins) begin
            mem[w_idx] <= byte_merge(mem[w_idx], r_wdata, r_be);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= 9'd0;
            r_addr  <= 32'h0;
            r_rd    <= 1'b0;
            r_wr    <= 1'b0;
            r_wdata <= 32'h0;
            r_be    <= 4'h0;
            r_perr  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_req) begin
                        r_addr  <= bus.address;
                        r_rd    <= bus.read;
                        r_wr    <= bus.write;
                        r_wdata <= bus.writedata;
                        r_be    <= bus.byteenable;
                        if (bus.read && bus.write) r_perr <= 1'b1;
                        if (w_wait_total == 9'd0) begin
                            r_state <= ST_ACK;
                        end else begin
                            r_state <= ST_WAIT;
                            r_cnt   <= w_wait_total - 9'd1;
                        end
                    end
                end
                ST_WAIT: begin
                    if (!w_req) begin
                        r_state <= ST_IDLE;
                    end else begin
                        if ((bus.address != r_addr) || (bus.read != r_rd) ||
                            (bus.write != r_wr)) begin
                            r_perr <= 1'b1;
                        end
                        if (r_cnt == 9'd0) r_state <= ST_ACK;
                        else               r_cnt   <= r_cnt - 9'd1;
                    end
                end
                ST_ACK:  r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_avalon_ram_responder.sv
// ============================================================================
// Module  : tb_avalon_ram_responder
// Purpose : Scoreboard bench for avalon_ram_responder (WAIT_CYCLES=2).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_avalon_ram_responder;

    localparam int WAITS = 2;

    logic        clk;
    logic        reset;
    logic        load_en;
    logic [31:0] load_addr;
    logic [31:0] load_data;
    logic        protocol_err;

    avalon_ram_if bus ();

    avalon_ram_responder #(
        .DEPTH       (1024),
        .BASE_ADDR   (32'h0000_0000),
        .WAIT_CYCLES (WAITS)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .load_en      (load_en),
        .load_addr    (load_addr),
        .load_data    (load_data),
        .protocol_err (protocol_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] model [1024];
    logic [31:0] exp_q [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = o;
        for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = n[8*i +: 8];
        return r;
    endfunction

    task automatic preload(input logic [31:0] addr, input logic [31:0] data);
        @(posedge clk); #1;
        load_en = 1'b1; load_addr = addr; load_data = data;
        @(posedge clk); #1;
        load_en = 1'b0;
        if (addr[31:2] < 30'd1024) model[addr[11:2]] = data;
    endtask

    // Runs one bus access; reads push their expected word and pop it at ACK.
    task automatic access(input string tag, input logic rd, input logic wr,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, input bit collide,
                          input logic [31:0] col_data);
        int ws;
        bit done;
        logic [31:0] e;
        ws = 0; done = 0;
        @(posedge clk); #1;
        bus.read = rd; bus.write = wr; bus.address = addr;
        bus.writedata = wdata; bus.byteenable = be;
        if (rd && !wr) exp_q.push_back((addr[31:2] < 30'd1024) ? model[addr[11:2]] : 32'h0);
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (!bus.waitrequest) begin
                done = 1;
                break;
            end
            ws++;
        end
        if (!done) begin
            check({tag, "_timeout"}, 32'h0, 32'h1);
            bus.read = 1'b0; bus.write = 1'b0;
            return;
        end
`ifdef AVALON_RAM_VARWAIT_EN
        check({tag, "_waits"}, 32'((ws >= WAITS + 1) && (ws <= WAITS + 4)), 32'h1);
`else
        check({tag, "_waits"}, 32'(ws), 32'(WAITS + 1));
`endif
        if (rd && !wr) begin
            e = exp_q.pop_front();
            check({tag, "_rdata"}, bus.readdata, e);
        end
        if (collide) begin
            load_en = 1'b1; load_addr = addr; load_data = col_data;
        end
        @(posedge clk); #1;
        load_en = 1'b0;
        bus.read = 1'b0; bus.write = 1'b0;
        if (wr && addr[31:2] < 30'd1024)
            model[addr[11:2]] = collide ? col_data : merge(model[addr[11:2]], wdata, be);
        @(negedge clk);
        check({tag, "_rdata_idle"}, bus.readdata, 32'h0);
    endtask

    initial begin
        bit done;
        logic [31:0] e;
        for (int i = 0; i < 1024; i++) model[i] = 32'h0;
        reset = 1'b0; load_en = 1'b0; load_addr = '0; load_data = '0;
        bus.read = 1'b0; bus.write = 1'b0; bus.address = '0;
        bus.writedata = '0; bus.byteenable = '0;
        // Zero the array through the preload port so reads are deterministic.
        for (int i = 0; i < 64; i++) begin
            @(posedge clk); #1;
            load_en = 1'b1; load_addr = 32'(i * 4); load_data = 32'h0;
        end
        @(posedge clk); #1;
        load_en = 1'b0;
        @(negedge clk);
        check("rst_waitreq", 32'(bus.waitrequest), 32'h0);
        check("rst_rdata", bus.readdata, 32'h0);
        check("rst_perr", 32'(protocol_err), 32'h0);
        reset = 1'b1;

        // Basic read latency
        preload(32'h04, 32'h2402_0010);
        access("t1_read", 1, 0, 32'h04, 32'h0, 4'h0, 0, 32'h0);

        // Byte-lane write
        preload(32'h08, 32'h1122_3344);
        access("t2_write", 0, 1, 32'h08, 32'hAABB_CCDD, 4'b0101, 0, 32'h0);
        access("t2_read", 1, 0, 32'h08, 32'h0, 4'h0, 0, 32'h0);
        check("t2_model", model[2], 32'h11BB_33DD);

        // Aborted write leaves memory untouched
        preload(32'h0C, 32'h0BAD_F00D);
        @(posedge clk); #1;
        bus.write = 1'b1; bus.address = 32'h0C;
        bus.writedata = 32'hFFFF_FFFF; bus.byteenable = 4'hF;
        @(posedge clk); #1;
        bus.write = 1'b0;
        @(posedge clk);
        access("t3_read", 1, 0, 32'h0C, 32'h0, 4'h0, 0, 32'h0);
        check("t3_perr", 32'(protocol_err), 32'h0);

        // Load beats a bus write to the same word in the same cycle
        access("col_write", 0, 1, 32'h30, 32'h1234_5678, 4'hF, 1, 32'hCAFE_BABE);
        access("col_read", 1, 0, 32'h30, 32'h0, 4'h0, 0, 32'h0);

        // Out of range read/write
        preload(32'h00, 32'h5A5A_A5A5);
        access("t5_oor_read", 1, 0, 32'h1000, 32'h0, 4'h0, 0, 32'h0);
        access("t5_oor_write", 0, 1, 32'h1000, 32'hDEAD_BEEF, 4'hF, 0, 32'h0);
        access("t5_read0", 1, 0, 32'h00, 32'h0, 4'h0, 0, 32'h0);
        check("t5_perr", 32'(protocol_err), 32'h0);

        // Simultaneous read and write
        access("t4_rw", 1, 1, 32'h10, 32'h5, 4'hF, 0, 32'h0);
        check("t4_perr", 32'(protocol_err), 32'h1);
        access("t4_read", 1, 0, 32'h10, 32'h0, 4'h0, 0, 32'h0);

        // Reset mid-WAIT
        preload(32'h20, 32'h7777_1234);
        @(posedge clk); #1;
        bus.read = 1'b1; bus.address = 32'h20;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("t6_rdata", bus.readdata, 32'h0);
        check("t6_perr", 32'(protocol_err), 32'h0);
        check("t6_waitreq", 32'(bus.waitrequest), 32'h1);
        @(posedge clk); #1;
        bus.read = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        access("t6_read20", 1, 0, 32'h20, 32'h0, 4'h0, 0, 32'h0);
        access("t6_read04", 1, 0, 32'h04, 32'h0, 4'h0, 0, 32'h0);

        // Address change during WAIT: latched address used, error flagged
        @(posedge clk); #1;
        bus.read = 1'b1; bus.address = 32'h04;
        exp_q.push_back(model[1]);
        @(posedge clk); #1;
        bus.address = 32'h08;
        done = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (!bus.waitrequest) begin
                done = 1;
                break;
            end
        end
        if (!done) check("t7_timeout", 32'h0, 32'h1);
        e = exp_q.pop_front();
        check("t7_rdata", bus.readdata, e);
        check("t7_perr", 32'(protocol_err), 32'h1);
        @(posedge clk); #1;
        bus.read = 1'b0;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
